// File: rtl/i2c_txn_master_if.sv
// Host-side request/status bundle for i2c_txn_master plus the scl it drives.
// 'master' is the requesting host, 'slave' is the frame generator serving it.
interface i2c_txn_master_if #(
    parameter int SLV_ADDR_SIZE = 7,
    parameter int DATAWIDTH     = 8
);
    logic                     start;
    logic                     rw;
    logic [SLV_ADDR_SIZE-1:0] slv_addr;
    logic [DATAWIDTH-1:0]     mem_addr;
    logic [DATAWIDTH-1:0]     wr_data;
    logic                     busy;
    logic                     done;
    logic                     ack_err;
    logic                     scl;

    modport master (
        output start, rw, slv_addr, mem_addr, wr_data,
        input  busy, done, ack_err, scl
    );

    modport slave (
        input  start, rw, slv_addr, mem_addr, wr_data,
        output busy, done, ack_err, scl
    );
endinterface

// File: rtl/i2c_txn_master.sv
// Single-transaction I2C master: START, {addr,rw} / mem_addr / wr_data bytes with
// per-byte ACK sampling, then STOP. scl is push-pull, sda is open-drain.
module i2c_txn_master #(
    parameter int CLK_DIV       = 4,
    parameter int SLV_ADDR_SIZE = 7,
    parameter int DATAWIDTH     = 8
) (
    input  logic            clk,
    input  logic            reset,
    i2c_txn_master_if.slave host,
    inout  wire             sda
);
    localparam int QW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATAWIDTH);

    typedef enum logic [2:0] {
        IDLE, START_A, START_B, BIT, ACK, STOP_A, STOP_B, STOP_C
    } state_t;

    state_t                 state_r;
    logic [QW-1:0]          qcnt_r;
    logic [1:0]             quarter_r;
    logic [1:0]             byte_idx_r;
    logic [3:0]             bit_cnt_r;
    logic                   rw_r;
    logic                   scl_r;
    logic                   sda_low_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   ack_err_r;
    logic                   nack_r;
    logic [SLV_ADDR_SIZE:0] byte0_r;
    logic [DATAWIDTH-1:0]   byte1_r;
    logic [DATAWIDTH-1:0]   byte2_r;
    logic [DATAWIDTH-1:0]   cur_byte_s;
    logic [DATAWIDTH-1:0]   next_byte_s;
    logic [3:0]             next_pos_s;
    logic                   q_end_s;
    logic                   last_byte_s;

    function automatic logic [DATAWIDTH-1:0] pick_byte(
        input logic [1:0]           idx,
        input logic [DATAWIDTH-1:0] b0,
        input logic [DATAWIDTH-1:0] b1,
        input logic [DATAWIDTH-1:0] b2
    );
        case (idx)
            2'd0:    pick_byte = b0;
            2'd1:    pick_byte = b1;
            default: pick_byte = b2;
        endcase
    endfunction

    assign q_end_s     = (qcnt_r == QW'(CLK_DIV - 1));
    assign cur_byte_s  = pick_byte(byte_idx_r, byte0_r, byte1_r, byte2_r);
    assign next_byte_s = pick_byte(byte_idx_r + 2'd1, byte0_r, byte1_r, byte2_r);
    assign next_pos_s  = bit_cnt_r - 4'd1;
    assign last_byte_s = rw_r ? (byte_idx_r == 2'd1) : (byte_idx_r == 2'd2);

    assign sda          = sda_low_r ? 1'b0 : 1'bz;
    assign host.scl     = scl_r;
    assign host.busy    = busy_r;
    assign host.done    = done_r;
    assign host.ack_err = ack_err_r;

    // Frame sequencer: pacing counters, position tracking and all bus/status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            qcnt_r     <= {QW{1'b0}};
            quarter_r  <= 2'd0;
            byte_idx_r <= 2'd0;
            bit_cnt_r  <= 4'd0;
            rw_r       <= 1'b0;
            scl_r      <= 1'b1;
            sda_low_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ack_err_r  <= 1'b0;
            nack_r     <= 1'b0;
            byte0_r    <= {(SLV_ADDR_SIZE+1){1'b0}};
            byte1_r    <= {DATAWIDTH{1'b0}};
            byte2_r    <= {DATAWIDTH{1'b0}};
        end else begin
            done_r <= 1'b0;
            if (state_r != IDLE) begin
                if (q_end_s) begin
                    qcnt_r    <= {QW{1'b0}};
                    quarter_r <= quarter_r + 2'd1;
                end else begin
                    qcnt_r <= qcnt_r + QW'(1);
                end
            end
            case (state_r)
                IDLE: begin
                    if (host.start) begin
                        rw_r       <= host.rw;
                        byte0_r    <= {host.slv_addr, host.rw};
                        byte1_r    <= host.mem_addr;
                        byte2_r    <= host.wr_data;
                        ack_err_r  <= 1'b0;
                        nack_r     <= 1'b0;
                        busy_r     <= 1'b1;
                        qcnt_r     <= {QW{1'b0}};
                        quarter_r  <= 2'd0;
                        byte_idx_r <= 2'd0;
                        bit_cnt_r  <= 4'(DATAWIDTH - 1);
                        state_r    <= START_A;
                    end
                end
                START_A: begin
                    if (q_end_s) begin
                        sda_low_r <= 1'b1;
                        state_r   <= START_B;
                    end
                end
                START_B: begin
                    if (q_end_s) begin
                        quarter_r <= 2'd0;
                        scl_r     <= 1'b0;
                        sda_low_r <= ~cur_byte_s[bit_cnt_r[BW-1:0]];
                        state_r   <= BIT;
                    end
                end
                BIT: begin
                    if (q_end_s && quarter_r == 2'd1) begin
                        scl_r <= 1'b1;
                    end else if (q_end_s && quarter_r == 2'd3) begin
                        scl_r <= 1'b0;
                        if (bit_cnt_r == 4'd0) begin
                            sda_low_r <= 1'b0;
                            state_r   <= ACK;
                        end else begin
                            bit_cnt_r <= next_pos_s;
                            sda_low_r <= ~cur_byte_s[next_pos_s[BW-1:0]];
                        end
                    end
                end
                ACK: begin
                    if (q_end_s && quarter_r == 2'd1) begin
                        scl_r <= 1'b1;
                    end else if (q_end_s && quarter_r == 2'd2) begin
                        nack_r <= sda;
                    end else if (q_end_s && quarter_r == 2'd3) begin
                        scl_r <= 1'b0;
                        // A NACK abandons any remaining bytes and heads straight to STOP.
                        if (nack_r || last_byte_s) begin
                            if (nack_r) begin
                                ack_err_r <= 1'b1;
                            end
                            sda_low_r <= 1'b1;
                            state_r   <= STOP_A;
                        end else begin
                            byte_idx_r <= byte_idx_r + 2'd1;
                            bit_cnt_r  <= 4'(DATAWIDTH - 1);
                            sda_low_r  <= ~next_byte_s[DATAWIDTH-1];
                            state_r    <= BIT;
                        end
                    end
                end
                STOP_A: begin
                    if (q_end_s) begin
                        scl_r   <= 1'b1;
                        state_r <= STOP_B;
                    end
                end
                STOP_B: begin
                    if (q_end_s) begin
                        sda_low_r <= 1'b0;
                        state_r   <= STOP_C;
                    end
                end
                STOP_C: begin
                    if (q_end_s) begin
                        quarter_r <= 2'd0;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    scl_r     <= 1'b1;
                    sda_low_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_txn_master.sv
// Bench for i2c_txn_master: a CLK_DIV=4 and a CLK_DIV=2 instance share one
// host driver and one behavioural I2C slave/monitor, selected by 'sel'.
module tb_i2c_txn_master;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic       start_v = 1'b0;
    logic       f_rw = 1'b0;
    logic [6:0] f_slv = 7'h00;
    logic [7:0] f_mem = 8'h00;
    logic [7:0] f_wd = 8'h00;
    logic       drive = 1'b0;

    wire sda1;
    wire sda2;
    pullup (sda1);
    pullup (sda2);

    i2c_txn_master_if #(.SLV_ADDR_SIZE(7), .DATAWIDTH(8)) if1 ();
    i2c_txn_master_if #(.SLV_ADDR_SIZE(7), .DATAWIDTH(8)) if2 ();

    assign if1.start = start_v & ~sel;
    assign if2.start = start_v & sel;
    assign if1.rw = f_rw;        assign if2.rw = f_rw;
    assign if1.slv_addr = f_slv; assign if2.slv_addr = f_slv;
    assign if1.mem_addr = f_mem; assign if2.mem_addr = f_mem;
    assign if1.wr_data = f_wd;   assign if2.wr_data = f_wd;
    assign sda1 = (drive && !sel) ? 1'b0 : 1'bz;
    assign sda2 = (drive && sel) ? 1'b0 : 1'bz;

    i2c_txn_master #(.CLK_DIV(4), .SLV_ADDR_SIZE(7), .DATAWIDTH(8)) u_div4 (
        .clk(clk), .reset(reset), .host(if1.slave), .sda(sda1));
    i2c_txn_master #(.CLK_DIV(2), .SLV_ADDR_SIZE(7), .DATAWIDTH(8)) u_div2 (
        .clk(clk), .reset(reset), .host(if2.slave), .sda(sda2));

    wire m_scl  = sel ? if2.scl : if1.scl;
    wire m_sda  = sel ? sda2 : sda1;
    wire m_busy = sel ? if2.busy : if1.busy;
    wire m_done = sel ? if2.done : if1.done;
    wire m_err  = sel ? if2.ack_err : if1.ack_err;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Behavioural slave/monitor sampled mid-cycle: decodes START/STOP, collects
    // bytes, ACKs unless told to NACK a byte, and measures scl high phases.
    logic [7:0] rx[$];
    logic [7:0] sh = 8'h00;
    int  bitcnt = 0, starts = 0, stops = 0, nack_at = -1;
    int  hi_len = 0, hi_min = 0, hi_max = 0;
    bit  hi_valid = 1'b0;
    logic p_scl = 1'b1, p_sda = 1'b1;

    always @(negedge clk) begin
        if (reset) begin
            drive  = 1'b0;
            bitcnt = 0;
        end else if (p_scl && m_scl && p_sda && !m_sda) begin
            starts++;
            bitcnt = 0;
        end else if (p_scl && m_scl && !p_sda && m_sda) begin
            stops++;
        end else if (!p_scl && m_scl) begin
            if (bitcnt < 8) sh = {sh[6:0], m_sda};
            bitcnt++;
            if (bitcnt == 8) rx.push_back(sh);
            hi_len = 1;
            hi_valid = 1'b1;
        end else if (p_scl && !m_scl) begin
            if (hi_valid) begin
                if (hi_len < hi_min) hi_min = hi_len;
                if (hi_len > hi_max) hi_max = hi_len;
            end
            hi_valid = 1'b0;
            if (bitcnt == 8) begin
                drive = (int'(rx.size()) - 1 != nack_at);
            end else if (bitcnt == 9) begin
                drive = 1'b0;
                bitcnt = 0;
            end
        end else if (m_scl && hi_valid) begin
            hi_len++;
        end
        p_scl = m_scl;
        p_sda = m_sda;
    end

    // One frame: request, optional ignored mid-frame start, wait for done, then check.
    task automatic run_frame(input logic rw, input logic [6:0] slv, input logic [7:0] mem,
                             input logic [7:0] wd, input int nack, input int ignore_at,
                             input int exp_lat, input logic exp_err, input int exp_nb,
                             input bit b2b_next, input string tag);
        logic [7:0] exp_q[$];
        int  k, d;
        bit  got;
        d = sel ? 2 : 4;
        exp_q.push_back({slv, rw});
        exp_q.push_back(mem);
        exp_q.push_back(wd);
        while (int'(exp_q.size()) > exp_nb) void'(exp_q.pop_back());
        rx.delete();
        starts = 0; stops = 0; nack_at = nack;
        hi_valid = 1'b0; hi_min = 1000; hi_max = 0;
        f_rw = rw; f_slv = slv; f_mem = mem; f_wd = wd;
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        k = 1;
        check(m_busy == 1'b1, {tag, "_busy_rise"}, int'(m_busy), 1);
        check(m_err == 1'b0, {tag, "_err_clear"}, int'(m_err), 0);
        got = 1'b0;
        while (k < 4000 && !got) begin
            if (m_done) begin
                got = 1'b1;
                start_v = 1'b0;
            end else begin
                if (k == ignore_at) begin
                    f_rw = ~rw; f_slv = ~slv; f_mem = ~mem; f_wd = ~wd;
                    start_v = 1'b1;
                end else begin
                    start_v = 1'b0;
                end
                @(negedge clk);
                k++;
            end
        end
        check(got, {tag, "_done_seen"}, int'(got), 1);
        if (got) begin
            check(k - 1 == exp_lat, {tag, "_latency"}, k - 1, exp_lat);
            check(m_busy == 1'b0, {tag, "_busy_at_done"}, int'(m_busy), 0);
            check(m_err == exp_err, {tag, "_ack_err"}, int'(m_err), int'(exp_err));
            check(int'(rx.size()) == exp_nb, {tag, "_nbytes"}, int'(rx.size()), exp_nb);
            for (int i = 0; i < exp_nb && i < int'(rx.size()); i++)
                check(rx[i] == exp_q[i], {tag, "_byte"}, int'(rx[i]), int'(exp_q[i]));
            check(starts == 1 && stops == 1, {tag, "_start_stop"}, starts * 10 + stops, 11);
            check(hi_min == 2 * d && hi_max == 2 * d, {tag, "_scl_high"}, hi_min * 1000 + hi_max,
                  2 * d * 1000 + 2 * d);
            if (!b2b_next) begin
                @(negedge clk);
                check(m_done == 1'b0 && m_busy == 1'b0, {tag, "_done_width"}, int'(m_done), 0);
            end
        end
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] slv;
        logic [7:0] mem;
        logic [7:0] wd;
        int         nack;
        int         exp_lat;
        logic       exp_err;
        int         exp_nb;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int  nb, sent, q, nack;
        logic rw;
        logic [6:0] slv;
        logic [7:0] mem, wd;
        bit  done_seen;

        tbl[0] = '{1'b0, 7'h2A, 8'h15, 8'hC3, -1, 452, 1'b0, 3};
        tbl[1] = '{1'b1, 7'h2A, 8'h07, 8'h99, -1, 308, 1'b0, 2};
        tbl[2] = '{1'b0, 7'h2A, 8'h15, 8'hC3,  0, 164, 1'b1, 1};
        tbl[3] = '{1'b0, 7'h2A, 8'h15, 8'hC3, -1, 452, 1'b0, 3};
        tbl[4] = '{1'b1, 7'h11, 8'hA5, 8'h00,  1, 308, 1'b1, 2};
        tbl[5] = '{1'b0, 7'h7F, 8'h00, 8'hFF,  2, 452, 1'b1, 3};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check(if1.scl == 1'b1 && if2.scl == 1'b1, "rst_scl", int'(if1.scl), 1);
        check(sda1 === 1'b1 && sda2 === 1'b1, "rst_sda", int'(sda1), 1);
        check(if1.busy == 1'b0 && if1.done == 1'b0 && if1.ack_err == 1'b0, "rst_status",
              int'({if1.busy, if1.done, if1.ack_err}), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_frame(tbl[i].rw, tbl[i].slv, tbl[i].mem, tbl[i].wd, tbl[i].nack, -1,
                      tbl[i].exp_lat, tbl[i].exp_err, tbl[i].exp_nb, 1'b0, $sformatf("vec%0d", i));

        // Ignored start 100 cycles in, then a back-to-back request in the done cycle.
        run_frame(1'b0, 7'h2A, 8'h15, 8'hC3, -1, 100, 452, 1'b0, 3, 1'b1, "ignore");
        run_frame(1'b1, 7'h2A, 8'h07, 8'h00, -1, -1, 308, 1'b0, 2, 1'b0, "b2b");

        // Randomised frames against a frame-length / byte-count reference model.
        for (int r = 0; r < 8; r++) begin
            rw   = 1'($urandom_range(0, 1));
            slv  = 7'($urandom);
            mem  = 8'($urandom);
            wd   = 8'($urandom);
            nack = int'($urandom_range(0, 3)) - 1;
            nb   = rw ? 2 : 3;
            sent = (nack >= 0 && nack < nb) ? nack + 1 : nb;
            q    = 2 + 36 * sent + 3;
            run_frame(rw, slv, mem, wd, nack, -1, q * 4, (nack >= 0 && nack < nb), sent,
                      1'b0, $sformatf("rnd%0d", r));
        end

        // Reset during byte1: bus released at once, frame never completes.
        f_rw = 1'b0; f_slv = 7'h2A; f_mem = 8'h15; f_wd = 8'hC3; nack_at = -1;
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        repeat (169) @(negedge clk);
        check(if1.busy == 1'b1, "abort_busy_before", int'(if1.busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check(if1.scl == 1'b1, "abort_scl", int'(if1.scl), 1);
        check(sda1 === 1'b1, "abort_sda", int'(sda1), 1);
        check(if1.busy == 1'b0 && if1.done == 1'b0 && if1.ack_err == 1'b0, "abort_status",
              int'({if1.busy, if1.done, if1.ack_err}), 0);
        reset = 1'b0;
        done_seen = 1'b0;
        repeat (600) begin
            @(negedge clk);
            if (if1.done || if1.busy) done_seen = 1'b1;
        end
        check(!done_seen, "abort_no_done", int'(done_seen), 0);

        // CLK_DIV=2 instance: all-ones / all-zeros data and a read.
        sel = 1'b1;
        @(negedge clk);
        run_frame(1'b0, 7'h2A, 8'hFF, 8'h00, -1, -1, 226, 1'b0, 3, 1'b0, "div2_wr");
        run_frame(1'b1, 7'h55, 8'h00, 8'h00, -1, -1, 154, 1'b0, 2, 1'b0, "div2_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
